out_bcd_display: RTL and testbench
==================================

Name: out_bcd_display

Overview:
- Downstream consumer of the CPU `out` port.
- Converts the 16-bit output value to packed BCD using sequential double-dabble, one shift per clock.
- Drives one seven-segment pattern per digit for the board display, with leading-zero blanking.
- Converts only when the value changes, so a steady `out` costs no activity.

Parameters:
- DATA_WIDTH, 16, width of the binary input; must equal the CPU DATA_WIDTH.
- NUM_DIGITS, 5, number of BCD digits; must satisfy 10^NUM_DIGITS > 2^DATA_WIDTH - 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_data  in  DATA_WIDTH  binary value; connects to CPU `out`.
- busy  out  1  high while a conversion is in progress.
- valid  out  1  one-cycle pulse when `bcd` and `seg` take a new value.
- bcd  out  4*NUM_DIGITS  packed BCD; digit 0 (units) in bits [3:0].
- seg  out  7*NUM_DIGITS  active-high segments per digit, bit order {g,f,e,d,c,b,a}; digit 0 in bits [6:0].

Behaviour:
- Reset values:
  - State IDLE.
  - busy=0, valid=0, bcd=0.
  - last_val=0, primed=0, shift/scratch/counter registers=0.
  - seg reads digit0=7'h3F, all other digits blank (7'h00).
- States: IDLE, SHIFT, DONE.
- IDLE:
  - Starts a conversion if primed==0 or in_data != last_val.
  - On that edge: last_val<=in_data, bin<=in_data, scratch<=0, cnt<=DATA_WIDTH, primed<=1, go to SHIFT.
  - Otherwise stays in IDLE.
- SHIFT, each cycle:
  - Every scratch digit >=5 gets +3 (combinational).
  - Then {scratch,bin} shifts left by 1.
  - cnt decrements.
  - When cnt==1 at the edge: bcd<=final scratch, valid<=1, go to DONE.
- DONE: exactly one cycle; valid=1; next state IDLE with valid<=0.
- busy=1 in SHIFT and DONE, 0 in IDLE.
- Latency:
  - The edge that samples a new in_data is edge 0.
  - bcd updates at edge DATA_WIDTH (16).
  - valid is high for the following cycle.
  - The next sample is possible at edge DATA_WIDTH+1.
- in_data changes while busy:
  - Ignored until return to IDLE.
  - IDLE then compares against last_val, so the final settled value is always converted; intermediate values may be skipped.
- Value changes back to last_val while busy: no further conversion.
- Arithmetic:
  - scratch is 4*NUM_DIGITS bits; add-3 is per nibble, 4-bit, no carry between nibbles.
  - No overflow is possible under the parameter constraint.
- seg is combinational from the bcd register. Encoding for 0-9: 3F,06,5B,4F,66,6D,7D,07,7F,6F.
- Leading-zero blanking: digit k>0 is 7'h00 when it and all higher digits are 0. Digit 0 is never blanked.
- Reset asserted mid-conversion: immediate return to reset values. primed=0 forces a fresh conversion after release.

Optional Feature:
- Macro: OUT_BCD_SIGNED_EN.
- Defined:
  - in_data is treated as two's complement.
  - Extra output port `sign` (1 bit, reset 0), registered alongside bcd.
  - The magnitude is what gets converted: 0x8000 -> 32768.
  - sign=1 iff in_data[DATA_WIDTH-1]=1.
- Undefined:
  - Port is absent; unsigned conversion only.
- Latency is identical in both builds.

Decomposition:
- Shared package/include out_bcd_defs:
  - state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - seven-segment constants SEG_0..SEG_9 and SEG_BLANK;
  - NUM_DIGITS legality check constant.
- One sub-module: bcd_to_7seg (4-bit digit + blank -> 7-bit segments), instantiated NUM_DIGITS times in a generate loop.

Test Plan:
- Reset release with in_data=0 -> conversion forced by primed; valid pulses in cycle 17; bcd=20'h00000; seg={4x7'h00,7'h3F}.
- in_data=16'd12345 in IDLE -> after 16 SHIFT cycles bcd=20'h12345, valid one cycle, busy high for exactly 17 cycles.
- in_data=16'hFFFF -> bcd=20'h65535, all five digits lit. in_data=16'd7 -> bcd=20'h00007, digits 1-4 blank.
- in_data 100 -> 200 -> 300 during one conversion, settling at 300 -> first result 100, second conversion yields 20'h00300. No third conversion while 300 is held for 100 cycles.
- Reset asserted at SHIFT cycle 8 of a 12345 conversion -> outputs return to reset values at once; after release, the held value is reconverted with full 17-cycle latency.
- OUT_BCD_SIGNED_EN build:
  - 16'hFFFF -> sign=1, bcd=20'h00001;
  - 16'h8000 -> sign=1, bcd=20'h32768;
  - 16'h7FFF -> sign=0, bcd=20'h32767.

Source files
------------

// File: rtl/out_bcd_display_pkg.sv
// Shared definitions for out_bcd_display: FSM state encoding, seven-segment
// patterns and the digit-count legality check.
package out_bcd_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Segment bit order {g,f,e,d,c,b,a}, active high.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // True when NUM_DIGITS decimal digits can hold the largest DATA_WIDTH value.
  function automatic bit digits_ok(input int unsigned data_width,
                                   input int unsigned num_digits);
    longint unsigned p10;
    longint unsigned max_val;
    p10     = 64'd1;
    max_val = (64'd1 << data_width) - 64'd1;
    for (int unsigned i = 0; i < num_digits; i++) p10 = p10 * 64'd10;
    return p10 > max_val;
  endfunction

endpackage

// File: rtl/out_bcd_display_bcd_to_7seg.sv
// One BCD digit to seven-segment pattern, with a blank override.
module bcd_to_7seg
  import out_bcd_defs::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      unique case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/out_bcd_display.sv
// Sequential double-dabble of the CPU output value into BCD plus seven-segment
// drive with leading-zero blanking. Define OUT_BCD_SIGNED_EN for two's-complement input and a sign output.
module out_bcd_display
  import out_bcd_defs::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    busy,
  output logic                    valid,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic [7*NUM_DIGITS-1:0] seg
`ifdef OUT_BCD_SIGNED_EN
  ,
  output logic                    sign
`endif
);

  localparam int unsigned BW        = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W     = $clog2(DATA_WIDTH + 1);
  localparam bit          DIGITS_OK = digits_ok(DATA_WIDTH, NUM_DIGITS);

  if (!DIGITS_OK) begin : g_bad_digits
    $error("NUM_DIGITS too small to represent every DATA_WIDTH value");
  end

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] last_val;
  logic [DATA_WIDTH-1:0] bin;
  logic [DATA_WIDTH-1:0] mag;
  logic                  primed;
  logic [BW-1:0]         scratch;
  logic [BW-1:0]         adj;
  logic [CNT_W-1:0]      cnt;
  logic                  start;
  logic                  last_shift;
  logic [NUM_DIGITS-1:0] blank;

`ifdef OUT_BCD_SIGNED_EN
  logic neg_pend;

  // Converting the magnitude; 0x8000 negates to itself, which reads as 2^(W-1).
  always_comb mag = in_data[DATA_WIDTH-1] ? (~in_data + 1'b1) : in_data;
`else
  always_comb mag = in_data;
`endif

  always_comb begin
    start      = !primed || (in_data != last_val);
    last_shift = (cnt == CNT_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_shift) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != IDLE);
    valid = (state == DONE);
  end

  always_comb begin
    adj = scratch;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_val <= '0;
      bin      <= '0;
      scratch  <= '0;
      cnt      <= '0;
      primed   <= 1'b0;
      bcd      <= '0;
`ifdef OUT_BCD_SIGNED_EN
      neg_pend <= 1'b0;
      sign     <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: if (start) begin
          last_val <= in_data;
          bin      <= mag;
          scratch  <= '0;
          cnt      <= CNT_W'(DATA_WIDTH);
          primed   <= 1'b1;
`ifdef OUT_BCD_SIGNED_EN
          neg_pend <= in_data[DATA_WIDTH-1];
`endif
        end
        SHIFT: begin
          scratch <= {adj[BW-2:0], bin[DATA_WIDTH-1]};
          bin     <= {bin[DATA_WIDTH-2:0], 1'b0};
          cnt     <= cnt - 1'b1;
          if (last_shift) begin
            bcd <= {adj[BW-2:0], bin[DATA_WIDTH-1]};
`ifdef OUT_BCD_SIGNED_EN
            sign <= neg_pend;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // Scan from the top digit down; a digit blanks while everything above it is zero.
  always_comb begin
    logic seen_nz;
    seen_nz = 1'b0;
    blank   = '0;
    for (int unsigned i = NUM_DIGITS - 1; i > 0; i--) begin
      seen_nz  = seen_nz | (bcd[4*i +: 4] != 4'd0);
      blank[i] = !seen_nz;
    end
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    bcd_to_7seg u_seg (
      .digit (bcd[4*k +: 4]),
      .blank (blank[k]),
      .seg   (seg[7*k +: 7])
    );
  end

endmodule

// File: tb/tb_out_bcd_display.sv
// Self-checking bench for out_bcd_display: vector table, randomized values
// against a decimal reference model, and multi-cycle corner sequences.
module tb_out_bcd_display;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_data = '0;
  logic        busy, valid;
  logic [19:0] bcd;
  logic [34:0] seg;
`ifdef OUT_BCD_SIGNED_EN
  logic        sign;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] segtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  always #5 clk = ~clk;

  out_bcd_display #(.DATA_WIDTH(16), .NUM_DIGITS(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_data (in_data),
    .busy    (busy),
    .valid   (valid),
    .bcd     (bcd),
    .seg     (seg)
`ifdef OUT_BCD_SIGNED_EN
    ,
    .sign    (sign)
`endif
  );

  typedef struct {
    logic [15:0] in;
    logic [19:0] bcd;
    logic        sgn;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int unsigned mag_of(input logic [15:0] v);
`ifdef OUT_BCD_SIGNED_EN
    if (v[15]) return 32'd65536 - 32'(v);
`endif
    return 32'(v);
  endfunction

  function automatic logic sign_of(input logic [15:0] v);
`ifdef OUT_BCD_SIGNED_EN
    return v[15];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [19:0] bcd_of(input int unsigned m);
    logic [19:0] r;
    int unsigned p;
    r = '0;
    p = 1;
    for (int k = 0; k < 5; k++) begin
      r[4*k +: 4] = 4'((m / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [34:0] seg_of(input int unsigned m);
    logic [34:0] r;
    int unsigned p;
    r = '0;
    p = 1;
    for (int k = 0; k < 5; k++) begin
      if (k == 0 || m >= p) r[7*k +: 7] = segtab[(m / p) % 10];
      p = p * 10;
    end
    return r;
  endfunction

  // Waits for valid starting just before the sampling edge; lat is the
  // expected number of negedges up to and including the valid one.
  task automatic run_conv(input string name, input int lat, input logic [19:0] exp_bcd,
                          input logic [34:0] exp_seg, input logic exp_sgn);
    int n, nb;
    n  = 0;
    nb = 0;
    while (n < 60) begin
      @(negedge clk);
      n++;
      if (busy) nb++;
      if (valid) break;
    end
    check({name, "_latency"}, 64'(n), 64'(lat));
    check({name, "_bcd"}, 64'(bcd), 64'(exp_bcd));
    check({name, "_seg"}, 64'(seg), 64'(exp_seg));
`ifdef OUT_BCD_SIGNED_EN
    check({name, "_sign"}, 64'(sign), 64'(exp_sgn));
`else
    if (exp_sgn) check({name, "_sign_unsupported"}, 64'd0, 64'd1);
`endif
    @(negedge clk);
    if (busy) nb++;
    check({name, "_valid_pulse"}, 64'(valid), 64'd0);
    check({name, "_busy_cycles"}, 64'(nb), 64'(lat));
  endtask

  task automatic run_value(input string name, input logic [15:0] v);
    in_data = v;
    run_conv(name, 17, bcd_of(mag_of(v)), seg_of(mag_of(v)), sign_of(v));
  endtask

  task automatic check_quiet(input string name, input int cycles);
    int act;
    act = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (busy || valid) act++;
    end
    check(name, 64'(act), 64'd0);
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_valid"}, 64'(valid), 64'd0);
    check({name, "_bcd"}, 64'(bcd), 64'd0);
    check({name, "_seg"}, 64'(seg), {29'd0, 35'h3F});
`ifdef OUT_BCD_SIGNED_EN
    check({name, "_sign"}, 64'(sign), 64'd0);
`endif
  endtask

  initial begin
    logic [15:0] v, last;

`ifdef OUT_BCD_SIGNED_EN
    vecs[0] = '{16'd12345, 20'h12345, 1'b0};
    vecs[1] = '{16'hFFFF,  20'h00001, 1'b1};
    vecs[2] = '{16'd7,     20'h00007, 1'b0};
    vecs[3] = '{16'h8000,  20'h32768, 1'b1};
    vecs[4] = '{16'h7FFF,  20'h32767, 1'b0};
`else
    vecs[0] = '{16'd12345, 20'h12345, 1'b0};
    vecs[1] = '{16'hFFFF,  20'h65535, 1'b0};
    vecs[2] = '{16'd7,     20'h00007, 1'b0};
    vecs[3] = '{16'h8000,  20'h32768, 1'b0};
    vecs[4] = '{16'd1000,  20'h01000, 1'b0};
`endif

    // Reset and primed conversion of 0
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    run_conv("prime", 17, 20'h00000, {28'd0, 7'h3F}, 1'b0);

    for (int i = 0; i < 5; i++) begin
      in_data = vecs[i].in;
      run_conv($sformatf("vec%0d", i), 17, vecs[i].bcd, seg_of(mag_of(vecs[i].in)),
               vecs[i].sgn);
    end
    last = vecs[4].in;

    for (int i = 0; i < 20; i++) begin
      v = 16'($urandom);
      if (v == last) v = v ^ 16'h0001;
      run_value($sformatf("rand%0d", i), v);
      last = v;
    end

    // Intermediate values during busy are skipped; the settled one is converted
    in_data = 16'd100;
    repeat (3) @(negedge clk);
    in_data = 16'd200;
    repeat (3) @(negedge clk);
    in_data = 16'd300;
    run_conv("skip_first", 11, 20'h00100, seg_of(100), 1'b0);
    run_conv("skip_second", 17, 20'h00300, seg_of(300), 1'b0);
    check_quiet("hold_300_quiet", 100);

    // Returning to the value being converted causes no second conversion
    in_data = 16'd500;
    repeat (3) @(negedge clk);
    in_data = 16'd600;
    repeat (3) @(negedge clk);
    in_data = 16'd500;
    run_conv("back_to_last", 11, 20'h00500, seg_of(500), 1'b0);
    check_quiet("back_to_last_quiet", 30);

    // Reset in the middle of a conversion
    in_data = 16'd12345;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_state("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_conv("post_reset", 17, 20'h12345, seg_of(12345), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
